// File: rtl/csr_row_mac.sv
// csr_row_mac: pops CSR nonzero entries {last, col, val} from the PIC input
// FIFO, fetches x[col] from the dense-vector RAM and multiply-accumulates the
// products into a row sum. The end-of-row entry publishes the row result on a
// valid/ready port. One entry takes four cycles (IDLE, FDATA, VADDR, MAC).
// Each completed row adds its EMIT dwell.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   fifo_empty      FIFO empty flag
//   fifo_rd_en      FIFO pop pulse (combinational, IDLE only)
//   fifo_data       popped entry {last, col, val}, valid the cycle after the pop
//   vec_addr        registered vector RAM address
//   vec_data        vector RAM data, valid the cycle after vec_addr is presented
//   mat_start       restarts row numbering (honoured in IDLE only)
//   row_valid       row result valid, held until out_ready
//   out_ready       downstream accepts the row result
//   row_sum         signed row dot product, modulo 2**ACC_W
//   row_idx         row number of row_sum
//   row_nnz         number of entries accumulated into the row
module csr_row_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned ROW_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_W+IDX_W:0]   fifo_data,
  output logic [IDX_W-1:0]        vec_addr,
  input  logic [DATA_W-1:0]       vec_data,
  input  logic                    mat_start,
  output logic                    row_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        row_sum,
  output logic [ROW_W-1:0]        row_idx,
  output logic [IDX_W:0]          row_nnz
);

  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FDATA = 3'd1,
    VADDR = 3'd2,
    MAC   = 3'd3,
    EMIT  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] val_q, val_d;
  logic                     last_q, last_d;
  logic [IDX_W-1:0]         vec_addr_q, vec_addr_d;
  logic [ACC_W-1:0]         row_sum_q, row_sum_d;
  logic [ROW_W-1:0]         row_idx_q, row_idx_d;
  logic [CNT_W-1:0]         row_nnz_q, row_nnz_d;
  logic [CNT_W-1:0]         nnz_q, nnz_d;
  logic                     row_valid_q, row_valid_d;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  mac_sum_c;

  // Signed product of the latched value and the RAM word, sign-extended into the accumulator
  assign prod_c    = PROD_W'(val_q) * PROD_W'($signed(vec_data));
  assign mac_sum_c = acc_q + ACC_W'(prod_c);

  // Pop only from IDLE; reset masks the pop even though the FSM already sits in IDLE
  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !reset;

  assign vec_addr  = vec_addr_q;
  assign row_valid = row_valid_q;
  assign row_sum   = row_sum_q;
  assign row_idx   = row_idx_q;
  assign row_nnz   = row_nnz_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      val_q       <= '0;
      last_q      <= 1'b0;
      vec_addr_q  <= '0;
      row_sum_q   <= '0;
      row_idx_q   <= '0;
      row_nnz_q   <= '0;
      nnz_q       <= '0;
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      val_q       <= val_d;
      last_q      <= last_d;
      vec_addr_q  <= vec_addr_d;
      row_sum_q   <= row_sum_d;
      row_idx_q   <= row_idx_d;
      row_nnz_q   <= row_nnz_d;
      nnz_q       <= nnz_d;
      row_valid_q <= row_valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    val_d       = val_q;
    last_d      = last_q;
    vec_addr_d  = vec_addr_q;
    row_sum_d   = row_sum_q;
    row_idx_d   = row_idx_q;
    row_nnz_d   = row_nnz_q;
    nnz_d       = nnz_q;
    row_valid_d = row_valid_q;

    unique case (state_q)
      IDLE: begin
        if (mat_start) begin
          row_idx_d = '0;
          acc_d     = '0;
        end
        if (!fifo_empty) begin
          state_d = FDATA;
        end
      end
      FDATA: begin
        val_d      = $signed(fifo_data[DATA_W-1:0]);
        vec_addr_d = fifo_data[DATA_W +: IDX_W];
        last_d     = fifo_data[ENTRY_W-1];
        state_d    = VADDR;
      end
      VADDR: begin
        state_d = MAC;
      end
      MAC: begin
        if (last_q) begin
          row_sum_d   = mac_sum_c;
          row_nnz_d   = nnz_q + CNT_W'(1);
          acc_d       = '0;
          nnz_d       = '0;
          row_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          acc_d   = mac_sum_c;
          nnz_d   = nnz_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          row_valid_d = 1'b0;
          row_idx_d   = row_idx_q + ROW_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_row_mac.sv
module tb_csr_row_mac;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ACC_W   = 40;
  localparam int unsigned ROW_W   = 8;
  localparam int unsigned ENTRY_W = DATA_W + IDX_W + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [ENTRY_W-1:0]  fifo_data = '0;
  logic [IDX_W-1:0]    vec_addr;
  logic [DATA_W-1:0]   vec_data = '0;
  logic                mat_start;
  logic                row_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    row_sum;
  logic [ROW_W-1:0]    row_idx;
  logic [IDX_W:0]      row_nnz;

  csr_row_mac #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .ROW_W(ROW_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .vec_addr   (vec_addr),
    .vec_data   (vec_data),
    .mat_start  (mat_start),
    .row_valid  (row_valid),
    .out_ready  (out_ready),
    .row_sum    (row_sum),
    .row_idx    (row_idx),
    .row_nnz    (row_nnz)
  );

  always #5 clk = ~clk;

  // Upstream FIFO and vector RAM models
  logic [ENTRY_W-1:0]       fifo_mem [0:4095];
  int                       wr_ptr = 0;
  int                       rd_ptr = 0;
  logic signed [DATA_W-1:0] vec_mem [0:15];

  assign fifo_empty = (wr_ptr == rd_ptr);

  int cyc = 0;
  int pulse_n = 0;
  int pulse_cyc [0:4095];
  int viol = 0;
  logic prev_rd = 1'b0;

  int total = 0;
  int bad = 0;
  int row_seen_cyc = 0;

  // Pop/RAM behaviour plus protocol watch on fifo_rd_en
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) viol++;
      if (prev_rd) viol++;
      if (reset) viol++;
      pulse_cyc[pulse_n] = cyc;
      pulse_n++;
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
    prev_rd = fifo_rd_en;
    cyc++;
    vec_data <= vec_mem[vec_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one term of the row dot product, reduced modulo 2**ACC_W
  function automatic logic [ACC_W-1:0] prod40(input logic signed [DATA_W-1:0] v,
                                              input logic [IDX_W-1:0] c);
    longint p;
    p = longint'(v) * longint'(vec_mem[c]);
    return ACC_W'(p);
  endfunction

  task automatic push_entry(input logic last, input logic [IDX_W-1:0] col,
                            input logic signed [DATA_W-1:0] val);
    fifo_mem[wr_ptr] = {last, col, val};
    wr_ptr++;
  endtask

  task automatic push_rand_row(input int n, output logic [ACC_W-1:0] s);
    logic [IDX_W-1:0]         c;
    logic signed [DATA_W-1:0] v;
    s = '0;
    for (int k = 0; k < n; k++) begin
      c = IDX_W'($urandom_range(15, 0));
      v = DATA_W'($urandom);
      s = s + prod40(v, c);
      push_entry(k == n - 1, c, v);
    end
  endtask

  // Wait (bounded) for row_valid, check the result, and step past the handshake
  task automatic expect_row(input string tag, input logic [ACC_W-1:0] es,
                            input logic [ROW_W-1:0] ei, input logic [IDX_W:0] en);
    int n;
    n = 0;
    while (row_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    row_seen_cyc = cyc;
    chk({tag, "_valid"}, 64'(row_valid), 64'd1);
    chk({tag, "_sum"}, 64'(row_sum), 64'(es));
    chk({tag, "_idx"}, 64'(row_idx), 64'(ei));
    chk({tag, "_nnz"}, 64'(row_nnz), 64'(en));
    if (out_ready) @(negedge clk);
  endtask

  task automatic wait_pulses(input int target);
    int n;
    n = 0;
    while (pulse_n < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_wait", 64'(pulse_n >= target), 64'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    logic [ACC_W-1:0] s;
    logic [ROW_W-1:0] exp_idx;
    int p;
    int hs;
    int n;
    bit saw255;
    bit wrapped;

    reset = 1'b1;
    out_ready = 1'b1;
    mat_start = 1'b0;
    for (int i = 0; i < 16; i++) vec_mem[i] = DATA_W'($urandom);
    vec_mem[0]  = 16'sd10;
    vec_mem[1]  = 16'sd5;
    vec_mem[2]  = -16'sd1;
    vec_mem[3]  = 16'sd7;
    vec_mem[4]  = 16'sd1234;
    vec_mem[15] = -16'sd32768;

    // Reset state, with an entry already waiting in the FIFO
    push_entry(1'b1, 4'd3, 16'sd5);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(row_valid), 64'd0);
    chk("rst_sum", 64'(row_sum), 64'd0);
    chk("rst_idx", 64'(row_idx), 64'd0);
    chk("rst_nnz", 64'(row_nnz), 64'd0);
    chk("rst_vaddr", 64'(vec_addr), 64'd0);
    reset = 1'b0;
    exp_idx = '0;

    // Single-entry row: 5 * x[3] = 35, result four cycles after the pop
    expect_row("t1", 40'd35, exp_idx, 5'd1);
    chk("t1_npulse", 64'(pulse_n), 64'd1);
    chk("t1_lat", 64'(row_seen_cyc), 64'(pulse_cyc[0] + 4));
    exp_idx++;

    // Three entries with negatives: 20 - 15 - 4 = 1
    p = pulse_n;
    push_entry(1'b0, 4'd0, 16'sd2);
    push_entry(1'b0, 4'd1, -16'sd3);
    push_entry(1'b1, 4'd2, 16'sd4);
    expect_row("t2", 40'd1, exp_idx, 5'd3);
    chk("t2_npulse", 64'(pulse_n - p), 64'd3);
    chk("t2_gap1", 64'(pulse_cyc[p+1] - pulse_cyc[p]), 64'd4);
    chk("t2_gap2", 64'(pulse_cyc[p+2] - pulse_cyc[p+1]), 64'd4);
    chk("t2_lat", 64'(row_seen_cyc), 64'(pulse_cyc[p+2] + 4));
    exp_idx++;

    // Back-pressure with the next row queued
    out_ready = 1'b0;
    push_entry(1'b1, 4'd4, -16'sd9);
    push_entry(1'b1, 4'd3, 16'sd100);
    expect_row("bp_a", prod40(-16'sd9, 4'd4), exp_idx, 5'd1);
    p = pulse_n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 64'(row_valid), 64'd1);
      chk("bp_sum_hold", 64'(row_sum), 64'(prod40(-16'sd9, 4'd4)));
      chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    chk("bp_no_pop", 64'(pulse_n), 64'(p));
    out_ready = 1'b1;
    hs = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("bp_pop_after_hs", 64'(pulse_cyc[p]), 64'(hs + 1));
    exp_idx++;
    expect_row("bp_b", 40'd700, exp_idx, 5'd1);
    exp_idx++;

    // FIFO runs dry mid-row
    push_entry(1'b0, 4'd0, 16'sd3);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    chk("stall_valid", 64'(row_valid), 64'd0);
    push_entry(1'b1, 4'd1, -16'sd7);
    expect_row("stall", prod40(16'sd3, 4'd0) + prod40(-16'sd7, 4'd1), exp_idx, 5'd2);
    exp_idx++;

    // mat_start during MAC is ignored (acc and row index kept)
    p = pulse_n;
    push_entry(1'b0, 4'd2, 16'sd6);
    push_entry(1'b1, 4'd0, 16'sd1);
    wait_pulses(p + 1);
    wait_cyc(pulse_cyc[p] + 3);
    mat_start = 1'b1;
    @(negedge clk);
    mat_start = 1'b0;
    expect_row("ms_mac", 40'd4, exp_idx, 5'd2);
    exp_idx++;

    // mat_start in IDLE restarts numbering
    mat_start = 1'b1;
    @(negedge clk);
    mat_start = 1'b0;
    exp_idx = '0;
    push_entry(1'b1, 4'd3, -16'sd2);
    expect_row("ms_idle", prod40(-16'sd2, 4'd3), exp_idx, 5'd1);
    exp_idx++;

    // Full-length row of extreme operands
    for (int k = 0; k < 16; k++) push_entry(k == 15, 4'd15, -16'sd32768);
    expect_row("full", 40'h04_0000_0000, exp_idx, 5'd16);
    exp_idx++;

    // Random rows
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(16, 1);
      push_rand_row(n, s);
      expect_row("rnd", s, exp_idx, (IDX_W+1)'(n));
      exp_idx++;
    end

    // Row index wrap 255 -> 0
    saw255 = 1'b0;
    wrapped = 1'b0;
    for (int r = 0; r < 300 && !wrapped; r++) begin
      push_rand_row(1, s);
      expect_row("wrap", s, exp_idx, 5'd1);
      if (exp_idx == 8'd255) saw255 = 1'b1;
      else if (saw255 && exp_idx == 8'd0) wrapped = 1'b1;
      exp_idx++;
    end
    chk("wrap_seen", 64'(wrapped), 64'd1);

    // Async reset in MAC mid-row with the next row already queued
    p = pulse_n;
    push_entry(1'b0, 4'd0, 16'sd1);
    push_entry(1'b0, 4'd1, 16'sd1);
    wait_pulses(p + 2);
    wait_cyc(pulse_cyc[p+1] + 3);
    push_entry(1'b1, 4'd3, 16'sd2);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(row_valid), 64'd0);
    chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("arst_idx", 64'(row_idx), 64'd0);
    @(negedge clk);
    chk("arst_rd_en_hold", 64'(fifo_rd_en), 64'd0);
    reset = 1'b0;
    exp_idx = '0;
    expect_row("arst_next", 40'd14, exp_idx, 5'd1);

    chk("rd_en_protocol", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_row_mac.md
Name: csr_row_mac

Overview:
- Consumer stage directly downstream of the PIC input FIFO in the sparse matrix-vector datapath.
- Pops one CSR nonzero entry at a time from the FIFO: value, column index and end-of-row flag.
- For each entry, fetches the matching dense-vector element from the vector RAM and multiply-accumulates it into the running row sum.
- On the end-of-row entry, presents the completed row result on a valid/ready output port.

Parameters:
- DATA_W, 16, signed width of matrix value and vector element.
- IDX_W, 4, column index width; the vector RAM holds 2**IDX_W entries.
- ACC_W, 40, accumulator and row_sum width.
- ROW_W, 8, row index counter width.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, asynchronous, active-high.
- fifo_empty, in, 1, PIC FIFO empty flag.
- fifo_rd_en, out, 1, FIFO read pulse: one cycle per entry.
- fifo_data, in, DATA_W+IDX_W+1, entry {last, col, val}, valid the cycle after fifo_rd_en.
- vec_addr, out, IDX_W, vector RAM read address (registered).
- vec_data, in, DATA_W, vector RAM read data, valid the cycle after vec_addr is presented.
- mat_start, in, 1, pulse that restarts row numbering for a new matrix.
- row_valid, out, 1, row result valid.
- out_ready, in, 1, downstream accepts the row result.
- row_sum, out, ACC_W, signed row dot product.
- row_idx, out, ROW_W, index of the row in row_sum.
- row_nnz, out, IDX_W+1, entries accumulated into the row.

Behaviour:
- Reset (async, reset high):
  - state=IDLE.
  - acc=0, val_r=0, last_r=0, vec_addr=0.
  - row_sum=0, row_idx=0, row_nnz=0, nnz_cnt=0, row_valid=0.
  - fifo_rd_en forced 0 while reset is high.
  - Reset mid-row discards the partial accumulation.
- State machine: IDLE -> FDATA -> VADDR -> MAC -> (IDLE | EMIT).
- Throughput: 4 cycles per entry; the EMIT dwell is added per row.
- IDLE:
  - fifo_rd_en = !fifo_empty (combinational, IDLE only).
  - If !fifo_empty, go to FDATA; otherwise stay in IDLE.
  - mat_start in IDLE sets row_idx=0 and acc=0; mat_start in any other state is ignored.
- FDATA:
  - Latch val_r<=fifo_data[DATA_W-1:0], vec_addr<=col, last_r<=fifo_data[MSB].
  - Go to VADDR.
- VADDR: the RAM samples vec_addr. Go to MAC.
- MAC:
  - prod = signed(val_r) * signed(vec_data), 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulation is two's-complement modulo 2**ACC_W with no saturation.
  - nnz_cnt increments by 1.
  - If last_r=0: acc <= acc+prod, then go to IDLE.
  - If last_r=1: row_sum <= acc+prod, row_nnz <= nnz_cnt+1, acc<=0, nnz_cnt<=0, row_valid<=1, then go to EMIT.
- EMIT:
  - row_valid, row_sum, row_idx and row_nnz are held stable until out_ready=1.
  - On the handshake cycle (row_valid & out_ready): row_valid<=0, row_idx<=row_idx+1 (wraps at 2**ROW_W to 0), go to IDLE.
  - No FIFO read occurs in EMIT, so back-pressure propagates to the FIFO, which fills and asserts full.
- Every row contains at least one entry; a row with no nonzeros is encoded upstream as one explicit {last=1, col, val=0} entry.
- fifo_rd_en is never asserted when fifo_empty=1, and never on two consecutive cycles.
- nnz_cnt of 2**IDX_W entries in one row is legal; row_nnz is IDX_W+1 bits to hold it.
- vec_addr holds its last value between entries.

Test Plan:
- Single-entry row: FIFO={1,col 3,val 5}, x[3]=7, out_ready=1 -> fifo_rd_en pulses once, then row_valid on the 4th cycle after the pulse with row_sum=35, row_idx=0, row_nnz=1.
- Three-entry row with negatives: (col0,2),(col1,-3),(col2,last,4) and x=[10,5,-1] -> row_sum=20-15-4=1, row_nnz=3, exactly 3 read pulses at 4-cycle spacing.
- Back-pressure: out_ready=0 for 10 cycles while the FIFO holds the next row -> row_valid and row_sum are held, fifo_rd_en=0 throughout, and the next pop follows the handshake by 1 cycle.
- Row index wrap and mat_start: emit 256 single-entry rows -> row_idx runs 255 then 0. mat_start in IDLE -> next row_idx=0. mat_start in MAC -> ignored.
- Empty stall: FIFO goes empty mid-row after entry 1 -> FSM waits in IDLE with fifo_rd_en=0. When the entry arrives, the accumulation continues correctly.
- Async reset asserted in MAC mid-row -> row_valid=0 and fifo_rd_en=0 immediately. After release, the next row sums from acc=0 and row_idx=0.
